// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight, buffers one instruction for IF/ID.
// Latency: instruction visible on if_* the cycle after imem_rvalid_i; peak one instruction per 2 cycles.
// Backpressure: stall_i freezes the output buffer; a new request is only raised when the buffer has room.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rdy_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus_4_o,
  output logic [31:0] if_insn_o,
  output logic        if_stall_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        discard_q;
  logic        buf_valid_q;
  logic [31:0] buf_pc_q;
  logic [31:0] buf_pc4_q;
  logic [31:0] buf_insn_q;

  logic        buf_room;
  logic        accept;
  logic        rsp;
  logic        load;
  logic        consume;
  logic [31:0] redirect_tgt;

  // The buffer has room when it is empty or being drained this cycle; the
  // REQ state only drives the request while that holds, so a response can
  // never arrive into a full buffer (it would otherwise be lost).
  assign buf_room     = !buf_valid_q || !stall_i;
  assign imem_req_o   = (state_q == REQ) && buf_room;
  assign imem_addr_o  = pc_q;
  assign accept       = imem_req_o && imem_rdy_i;
  assign rsp          = (state_q == WAIT) && imem_rvalid_i;
  assign load         = rsp && !discard_q && !redirect_i;
  assign consume      = buf_valid_q && !stall_i;
  assign redirect_tgt = redirect_pc_i & ~32'h0000_0003;

  // Fetch sequencing: PC advance, request/response handshake, stale-response tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          // A request accepted in a redirect cycle targets the old path.
          if (accept) begin
            state_q   <= WAIT;
            discard_q <= redirect_i;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            state_q   <= REQ;
            discard_q <= 1'b0;
          end else if (redirect_i) begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (redirect_i) begin
        pc_q <= redirect_tgt;
      end else if (accept) begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  // Single-entry output buffer: redirect flushes, a live response fills, an unstalled consumer drains.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_pc4_q   <= 32'h0;
      buf_insn_q  <= NOP;
    end else if (redirect_i) begin
      buf_valid_q <= 1'b0;
    end else if (load) begin
      // pc_q already stepped past the outstanding request when it was accepted.
      buf_valid_q <= 1'b1;
      buf_pc_q    <= pc_q - 32'd4;
      buf_pc4_q   <= pc_q;
      buf_insn_q  <= imem_rdata_i;
    end else if (consume) begin
      buf_valid_q <= 1'b0;
    end
  end

  assign if_valid_o     = buf_valid_q;
  assign if_pc_o        = buf_pc_q;
  assign if_pc_plus_4_o = buf_pc4_q;
  assign if_insn_o      = buf_valid_q ? buf_insn_q : NOP;
  assign if_stall_o     = !buf_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: a behavioural memory responder plus a transaction-level
// model of the fetch stream (next fetch PC, one outstanding request, one buffered instruction).
// Outputs are compared on the falling edge; inputs change 1 time unit after the rising edge.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req;
  logic [31:0] addr;
  logic        rdy;
  logic        rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] insn;
  logic        if_stall;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_started;
  bit          m_out;
  bit          m_live;
  bit          m_valid;
  logic [31:0] m_fetch_pc;
  logic [31:0] m_out_pc;
  logic [31:0] m_out_dat;
  logic [31:0] m_pc;
  logic [31:0] m_insn;
  int          m_lat;

  // Stimulus knobs (percentages, max response latency)
  int p_stall, p_redir, p_rdy, p_spur, max_lat, p_wrap;

  if_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .stall_i        (stall),
    .redirect_i     (redirect),
    .redirect_pc_i  (redirect_pc),
    .imem_req_o     (req),
    .imem_addr_o    (addr),
    .imem_rdy_i     (rdy),
    .imem_rvalid_i  (rvalid),
    .imem_rdata_i   (rdata),
    .if_valid_o     (valid),
    .if_pc_o        (pc),
    .if_pc_plus_4_o (pc4),
    .if_insn_o      (insn),
    .if_stall_o     (if_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic knobs(input int s, input int r, input int y, input int sp, input int ml, input int w);
    p_stall = s; p_redir = r; p_rdy = y; p_spur = sp; max_lat = ml; p_wrap = w;
  endtask

  task automatic model_reset();
    m_started  = 1'b0;
    m_out      = 1'b0;
    m_live     = 1'b0;
    m_valid    = 1'b0;
    m_fetch_pc = RST_PC;
    m_lat      = 0;
  endtask

  task automatic chk_reset_values();
    chk("rst_imem_req", req, 1'b0);
    chk("rst_imem_addr", addr, RST_PC);
    chk("rst_if_valid", valid, 1'b0);
    chk("rst_if_pc", pc, 32'h0);
    chk("rst_if_pc_plus_4", pc4, 32'h0);
    chk("rst_if_insn", insn, NOP);
    chk("rst_if_stall", if_stall, 1'b1);
  endtask

  // New random inputs for this cycle; the memory answers the outstanding request after m_lat cycles.
  task automatic drive();
    stall       = ($urandom_range(99) < p_stall);
    redirect    = ($urandom_range(99) < p_redir);
    redirect_pc = ($urandom_range(99) < p_wrap) ? (32'hFFFF_FFF0 + $urandom_range(15)) : $urandom;
    rdy         = ($urandom_range(99) < p_rdy);
    rdata       = $urandom;
    if (m_out) begin
      if (m_lat == 0) begin
        rvalid = 1'b1;
        rdata  = m_out_dat;
      end else begin
        rvalid = 1'b0;
        m_lat--;
      end
    end else begin
      rvalid = ($urandom_range(99) < p_spur);
    end
  endtask

  // Compare outputs with the model, then advance the model across the coming rising edge.
  task automatic check_step();
    bit exp_req, acc, got;
    exp_req = m_started && !m_out && (!m_valid || !stall);
    chk("imem_req", req, exp_req);
    if (exp_req) chk("imem_addr", addr, m_fetch_pc);
    chk("if_valid", valid, m_valid);
    chk("if_stall", if_stall, !m_valid);
    chk("if_insn", insn, m_valid ? m_insn : NOP);
    if (m_valid) begin
      chk("if_pc", pc, m_pc);
      chk("if_pc_plus_4", pc4, m_pc + 32'd4);
    end

    acc = exp_req && rdy;
    got = m_out && rvalid;

    if (redirect) m_valid = 1'b0;
    else if (got && m_live) begin
      m_valid = 1'b1;
      m_pc    = m_out_pc;
      m_insn  = rdata;
    end else if (m_valid && !stall) m_valid = 1'b0;

    if (got) m_out = 1'b0;
    if (acc) begin
      m_out     = 1'b1;
      m_live    = !redirect;
      m_out_pc  = m_fetch_pc;
      m_out_dat = $urandom;
      m_lat     = $urandom_range(max_lat, 0);
    end else if (redirect) begin
      m_live = 1'b0;
    end

    if (redirect) m_fetch_pc = redirect_pc & ~32'h0000_0003;
    else if (acc) m_fetch_pc = m_fetch_pc + 32'd4;
    m_started = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      drive();
      @(negedge clk);
      check_step();
    end
  endtask

  task automatic do_release();
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive();
    @(negedge clk);
    check_step();
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    rdy = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    model_reset();
    knobs(0, 0, 100, 0, 0, 0);
    #12;
    chk_reset_values();

    // Clean streaming from RESET_PC with a 1-cycle memory.
    do_release();
    run(40);
    // Downstream stalls only.
    knobs(60, 0, 100, 0, 0, 0);
    run(200);
    // Slow memory acceptance and redirects.
    knobs(20, 10, 30, 0, 2, 0);
    run(400);
    // Redirects near the top of the address space to exercise PC wrap.
    knobs(30, 8, 80, 10, 1, 80);
    run(400);
    // Everything random.
    knobs(35, 10, 60, 20, 3, 25);
    run(2000);

    // Reset while a request is outstanding, then a late response after release.
    knobs(0, 0, 100, 0, 3, 0);
    for (int i = 0; i < 50 && !m_out; i++) run(1);
    chk("outstanding_before_reset", m_out, 1'b1);
    @(posedge clk); #3;
    rst_n  = 1'b0;
    rvalid = 1'b0;
    #1;
    chk_reset_values();
    model_reset();
    knobs(0, 0, 100, 100, 0, 0);
    do_release();
    knobs(30, 10, 60, 20, 3, 20);
    run(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
